// File: rtl/addr_router_pkg.sv
// Shared types and the default address map for the address router.
package addr_router_pkg;

  localparam int MAP_AW = 32;
  localparam int WAIT_W = 4;

  // One slave region: inclusive [base, limit] plus wait states spent in ACCESS.
  typedef struct packed {
    logic [MAP_AW-1:0] base;
    logic [MAP_AW-1:0] limit;
    logic [WAIT_W-1:0] wait_st;
  } region_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index 0 = ROM, 1 = RAM, 2 = REG (leftmost pattern entry is the top index).
  localparam region_t [2:0] DEFAULT_MAP = '{
    '{base: 32'h0000_5000, limit: 32'h0000_5003, wait_st: 4'd0},
    '{base: 32'h0000_4600, limit: 32'h0000_4FFF, wait_st: 4'd1},
    '{base: 32'h0000_4000, limit: 32'h0000_45FF, wait_st: 4'd0}
  };

  // Write target that halts the router; deliberately outside every region.
  localparam logic [MAP_AW-1:0] HALT_ADDR = 32'h0000_5200;

endpackage

// File: rtl/region_match.sv
// Combinational inclusive range check of one address against one region.
module region_match
  import addr_router_pkg::*;
#(
  parameter int      AW     = 32,
  parameter region_t REGION = '0
) (
  input  logic [AW-1:0] addr,
  output logic          hit
);

  // Compare at the wider of the address and map widths so nothing truncates.
  localparam int XW = (AW > MAP_AW) ? AW : MAP_AW;

  logic [XW-1:0] a_ext;
  logic [XW-1:0] lo;
  logic [XW-1:0] hi;

  assign a_ext = XW'(addr);
  assign lo    = XW'(REGION.base);
  assign hi    = XW'(REGION.limit);
  assign hit   = (a_ext >= lo) && (a_ext <= hi);

endmodule

// File: rtl/addr_router.sv
// Single-master address router: decode, wait-state access, one-cycle response.
module addr_router
  import addr_router_pkg::*;
#(
  parameter int                  N_SLV = 3,
  parameter int                  AW    = 32,
  parameter int                  DW    = 32,
  parameter int                  CW    = 16,
  parameter region_t [N_SLV-1:0] MAP   = DEFAULT_MAP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata,
  output logic                ready,
  output logic                err,
  output logic                busy,
  output logic [N_SLV-1:0]    slv_sel,
  output logic [N_SLV-1:0]    slv_we,
  output logic [AW-1:0]       slv_addr,
  output logic [DW-1:0]       slv_wdata,
  input  logic [N_SLV*DW-1:0] slv_rdata,
  output logic                halted,
  output logic [CW-1:0]       txn_count
);

  localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int XW = (AW > MAP_AW) ? AW : MAP_AW;

  state_t            state_q, state_d;
  logic [IW-1:0]     sel_idx_q, sel_idx_d;
  logic              we_q, we_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [N_SLV-1:0]  slv_sel_q, slv_sel_d;
  logic [N_SLV-1:0]  slv_we_q, slv_we_d;
  logic [AW-1:0]     slv_addr_q, slv_addr_d;
  logic [DW-1:0]     slv_wdata_q, slv_wdata_d;
  logic              halted_q, halted_d;
  logic [CW-1:0]     txn_count_q, txn_count_d;

  logic [N_SLV-1:0]  hit;
  logic              hit_any;
  logic [IW-1:0]     hit_idx;
  logic [N_SLV-1:0]  hit_oh;
  logic              halt_hit;

  for (genvar g = 0; g < N_SLV; g++) begin : g_match
    region_match #(.AW(AW), .REGION(MAP[g])) u_match (
      .addr (addr),
      .hit  (hit[g])
    );
  end

  // Priority encode: scanning downward lets the lowest matching index win.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
    if (hit_any) hit_oh[hit_idx] = 1'b1;
  end

  assign halt_hit = we && !hit_any && (XW'(addr) == XW'(HALT_ADDR));

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d     = state_q;
    sel_idx_d   = sel_idx_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = err_q;
    slv_sel_d   = slv_sel_q;
    slv_we_d    = '0;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    halted_d    = halted_q;
    txn_count_d = txn_count_q;
    case (state_q)
      IDLE: begin
        if (req && !halted_q) begin
          we_d        = we;
          slv_wdata_d = wdata;
          if (hit_any) begin
            state_d    = ACCESS;
            sel_idx_d  = hit_idx;
            cnt_d      = MAP[hit_idx].wait_st;
            slv_sel_d  = hit_oh;
            slv_we_d   = we ? hit_oh : '0;
            slv_addr_d = addr - AW'(MAP[hit_idx].base);
          end else begin
            // Misses skip ACCESS; the halt write is the one miss that is not an error.
            state_d  = RESP;
            ready_d  = 1'b1;
            rdata_d  = '0;
            err_d    = !halt_hit;
            halted_d = halt_hit;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          ready_d    = 1'b1;
          err_d      = 1'b0;
          rdata_d    = we_q ? '0 : slv_rdata[sel_idx_q*DW +: DW];
          slv_sel_d  = '0;
          slv_addr_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        err_d       = 1'b0;
        txn_count_d = txn_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_idx_q   <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      slv_sel_q   <= '0;
      slv_we_q    <= '0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      halted_q    <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_idx_q   <= sel_idx_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      slv_sel_q   <= slv_sel_d;
      slv_we_q    <= slv_we_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      halted_q    <= halted_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign slv_sel   = slv_sel_q;
  assign slv_we    = slv_we_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign halted    = halted_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_addr_router.sv
// Randomized scoreboard bench for addr_router against a region-table model.
module tb_addr_router;
  import addr_router_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 12;   // narrow counter so the wrap is reached quickly

  localparam int unsigned RB [3] = '{32'h4000, 32'h4600, 32'h5000};
  localparam int unsigned RL [3] = '{32'h45FF, 32'h4FFF, 32'h5003};
  localparam int          RW [3] = '{0, 1, 0};

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req, we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata, rdata, slv_wdata;
  logic            ready, err, busy, halted;
  logic [N-1:0]    slv_sel, slv_we;
  logic [AW-1:0]   slv_addr;
  logic [N*DW-1:0] slv_rdata;
  logic [CW-1:0]   txn_count;

  addr_router #(.N_SLV(N), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy), .slv_sel(slv_sel),
    .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .halted(halted), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    logic [N-1:0]  sel;
    logic [N-1:0]  we1;
    logic [AW-1:0] off;
    logic [DW-1:0] wd;
    logic          halt;
    int            acc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first region (lowest index) whose inclusive range holds the address.
  function automatic exp_t model(input logic [AW-1:0] a, input logic w,
                                 input logic [DW-1:0] d, input logic [N*DW-1:0] srd);
    exp_t e;
    e.sel = '0; e.we1 = '0; e.off = '0; e.halt = 1'b0; e.rdata = '0;
    e.err = 1'b1; e.lat = 1; e.wd = d; e.acc = 0;
    for (int i = 0; i < 3; i++) begin
      if (e.sel == '0 && a >= RB[i] && a <= RL[i]) begin
        e.sel   = N'(1 << i);
        e.err   = 1'b0;
        e.lat   = RW[i] + 2;
        e.off   = a - RB[i];
        e.we1   = w ? e.sel : '0;
        e.rdata = w ? '0 : srd[i*DW +: DW];
      end
    end
    if (e.sel == '0 && w && a == 32'h5200) begin
      e.err  = 1'b0;
      e.halt = 1'b1;
    end
    return e;
  endfunction

  // Drive one request, push its expectation, then wait (bounded) for idle.
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [N*DW-1:0] srd);
    exp_t e;
    int   n;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; wdata = d; slv_rdata = srd;
    e = model(a, w, d, srd);
    @(posedge clk); #1;
    e.acc = cyc;
    sbq.push_back(e);
    n = 0;
    do begin
      req = 1'($urandom); addr = $urandom; we = 1'($urandom); wdata = $urandom;
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    req = 1'b0;
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle addr=%0h", a);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] edges [8];
    edges = '{32'h3FFF, 32'h4000, 32'h45FF, 32'h4600, 32'h4FFF, 32'h5000, 32'h5003, 32'h5004};
    case ($urandom_range(0, 9))
      0, 1:    return AW'($urandom_range(32'h4000, 32'h45FF));
      2, 3:    return AW'($urandom_range(32'h4600, 32'h4FFF));
      4:       return AW'($urandom_range(32'h5000, 32'h5003));
      5, 6:    return edges[$urandom_range(0, 7)];
      7:       return 32'h5200;
      8:       return $urandom;
      default: return AW'($urandom_range(32'h3F00, 32'h5400));
    endcase
  endfunction

  // Monitor: accumulates slave-side activity and checks each response against the queue.
  exp_t          mon_e;
  logic [CW-1:0] exp_cnt = '0;
  logic [N-1:0]  sel_or = '0, we_or = '0;
  logic [AW-1:0] off_seen = '0;
  int            we_pulses = 0;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      exp_cnt = '0; sel_or = '0; we_or = '0; off_seen = '0; we_pulses = 0;
    end else if (clk == 1'b0) begin
      if (slv_we != '0) begin we_pulses++; we_or |= slv_we; end
      if (slv_sel != '0) begin sel_or |= slv_sel; off_seen = slv_addr; end
      else if (slv_addr != '0) chk("slv_addr_idle", 64'(slv_addr), 64'd0);
      if (ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready actual=1 expected=0 (t=%0t)", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("rdata",     64'(rdata),          64'(mon_e.rdata));
          chk("err",       64'(err),            64'(mon_e.err));
          chk("latency",   64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
          chk("slv_sel",   64'(sel_or),         64'(mon_e.sel));
          chk("slv_we",    64'(we_or),          64'(mon_e.we1));
          chk("we_pulses", 64'(we_pulses),      64'(mon_e.we1 != '0));
          chk("slv_addr",  64'(off_seen),       64'(mon_e.off));
          chk("slv_wdata", 64'(slv_wdata),      64'(mon_e.wd));
          chk("halted",    64'(halted),         64'(mon_e.halt));
          chk("txn_count", 64'(txn_count),      64'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
          sel_or = '0; we_or = '0; off_seen = '0; we_pulses = 0;
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"},     64'(rdata),     64'd0);
    chk({tag, "_ready"},     64'(ready),     64'd0);
    chk({tag, "_err"},       64'(err),       64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_slv_sel"},   64'(slv_sel),   64'd0);
    chk({tag, "_slv_we"},    64'(slv_we),    64'd0);
    chk({tag, "_slv_addr"},  64'(slv_addr),  64'd0);
    chk({tag, "_slv_wdata"}, 64'(slv_wdata), 64'd0);
    chk({tag, "_halted"},    64'(halted),    64'd0);
    chk({tag, "_txn_count"}, 64'(txn_count), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic          w;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; slv_rdata = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");

    // Release just after an edge so the very next edge must accept the request.
    @(posedge clk); #2 reset = 1'b1;

    issue(32'h4004, 1'b0, 32'h1111_2222, {32'h0, 32'h0, 32'h0000_00AB});
    issue(32'h4610, 1'b1, 32'h0000_005A, {$urandom, $urandom, $urandom});
    issue(32'h6000, 1'b0, 32'h0,         {$urandom, $urandom, $urandom});
    issue(32'h5003, 1'b0, 32'h0,         {32'hCAFE_F00D, $urandom, $urandom});
    issue(32'h5200, 1'b0, 32'h0,         {$urandom, $urandom, $urandom});

    // Enough random traffic to carry the counter through its wrap.
    for (int k = 0; k < 4200; k++) begin
      a = rand_addr();
      w = 1'($urandom);
      if (a == 32'h5200) w = 1'b0;
      issue(a, w, $urandom, {$urandom, $urandom, $urandom});
    end

    // Abort a RAM write in its second ACCESS cycle.
    @(negedge clk);
    req = 1'b1; addr = 32'h4620; we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("abort_first_we", 64'(slv_we), 64'b010);
    @(posedge clk); #2 reset = 1'b0;
    #1 chk_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_hold_we", 64'(slv_we), 64'd0);
      chk("abort_hold_ready", 64'(ready), 64'd0);
    end
    @(posedge clk); #2 reset = 1'b1;

    for (int k = 0; k < 20; k++) begin
      a = rand_addr();
      if (a == 32'h5200) a = 32'h4400;
      issue(a, 1'($urandom), $urandom, {$urandom, $urandom, $urandom});
    end

    // Halt, then confirm later requests are ignored.
    issue(32'h5200, 1'b1, 32'h0, {$urandom, $urandom, $urandom});
    @(negedge clk);
    req = 1'b1; addr = 32'h4000; we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("halt_busy", 64'(busy), 64'd0);
      chk("halt_flag", 64'(halted), 64'd1);
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
